// File: rtl/fp16_result_collector_if.sv
// ---------------------------------------------------------------------------
// fp16_result_collector_if
//   Handshake bundle between a MAC result producer, the fp16 result
//   collector and its downstream consumer.
//
//   Signals:
//     in_valid  - producer has an fp16 result on in_data
//     in_data   - fp16 result word, [16] sign, [15:11] exponent, [10:1] mantissa
//     in_ready  - collector accepts a word this cycle
//     out_valid - out_data/out_class hold the oldest stored entry
//     out_data  - oldest stored result
//     out_class - class of out_data: [4] NaN, [3] Inf, [2] zero, [1] subnormal
//     out_ready - consumer takes the entry this cycle
//     level     - number of stored entries
//
//   Modports:
//     slave  - the collector's view
//     master - the producer/consumer environment's view
// ---------------------------------------------------------------------------
interface fp16_result_collector_if #(
  parameter int bw    = 16,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic [bw:1]   in_data;
  logic          in_ready;
  logic          out_valid;
  logic [bw:1]   out_data;
  logic [4:1]    out_class;
  logic          out_ready;
  logic [LW:1]   level;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_class, level
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_class, level
  );
endinterface

// File: rtl/fp16_result_collector.sv
// ---------------------------------------------------------------------------
// fp16_result_collector
//   Small FIFO that collects fp16 results from a MAC, classifies each word at
//   push time (NaN / Inf / zero / subnormal / normal) and stores the class
//   alongside the word. Entries leave in push order. A status FSM tracks
//   EMPTY / PARTIAL / FULL and drives registered in_ready / out_valid, so
//   there is no combinational path from out_ready to in_ready.
//
//   Parameters:
//     bw    - word width, only the 16-bit fp16 layout is supported
//     DEPTH - number of entries, power of two, >= 2
//
//   Ports:
//     CLK     - rising-edge clock
//     RESETn  - asynchronous active-low reset
//     bus     - fp16_result_collector_if.slave handshake bundle
//     nan_cnt - saturating count of pushed NaNs (only with FP16_COLLECT_STATS_EN)
//
//   Optional feature macro: FP16_COLLECT_STATS_EN
// ---------------------------------------------------------------------------
module fp16_result_collector #(
  parameter int bw    = 16,
  parameter int DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RESETn,
  fp16_result_collector_if.slave        bus
`ifdef FP16_COLLECT_STATS_EN
  ,
  output logic [8:1]                    nan_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } state_e;

  typedef struct packed {
    logic [4:1]  cls;
    logic [bw:1] data;
  } entry_t;

  entry_t            mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic [LW-1:0]     level_d;
  state_e            state_q;
  logic              in_ready_q;
  logic              out_valid_q;

  logic              push;
  logic              pop;
  logic [4:1]        in_cls;
  logic              exp_all_ones;
  logic              exp_zero;
  logic              man_zero;
  entry_t            rd_entry;

  // Handshakes qualified only by registered state.
  assign push = bus.in_valid & in_ready_q;
  assign pop  = out_valid_q & bus.out_ready;

  // Classification of the incoming word; the sign bit plays no part.
  assign exp_all_ones = (bus.in_data[15:11] == 5'h1F);
  assign exp_zero     = (bus.in_data[15:11] == 5'h00);
  assign man_zero     = (bus.in_data[10:1] == 10'h000);

  always_comb begin
    in_cls    = 4'b0000;
    in_cls[4] = exp_all_ones & ~man_zero;  // NaN
    in_cls[3] = exp_all_ones &  man_zero;  // Inf
    in_cls[2] = exp_zero     &  man_zero;  // zero
    in_cls[1] = exp_zero     & ~man_zero;  // subnormal
  end

  // NOTE: the storage array has no reset; nothing reads it while the FIFO is
  // empty, so clearing it would only add reset fan-out for no behaviour.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{cls: in_cls, data: bus.in_data};
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Simultaneous push and pop leaves the level unchanged.
  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  // Status FSM with registered in_ready / out_valid.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          // Pop is impossible here; with DEPTH >= 2 one push cannot fill it.
          if (push) begin
            state_q     <= ST_PARTIAL;
            out_valid_q <= 1'b1;
          end
        end
        ST_PARTIAL: begin
          if (push && !pop && (level_q == LW'(DEPTH - 1))) begin
            state_q    <= ST_FULL;
            in_ready_q <= 1'b0;
          end else if (pop && !push && (level_q == LW'(1))) begin
            state_q     <= ST_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        ST_FULL: begin
          // in_ready is low, so only a pop can move us.
          if (pop) begin
            state_q    <= ST_PARTIAL;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= ST_EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FP16_COLLECT_STATS_EN
  logic [8:1] nan_cnt_q;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      nan_cnt_q <= '0;
    end else if (push && in_cls[4] && (nan_cnt_q != 8'hFF)) begin
      nan_cnt_q <= nan_cnt_q + 8'd1;
    end
  end

  assign nan_cnt = nan_cnt_q;
`endif

  // Head of queue is gated by out_valid so an empty FIFO shows zeros
  // instead of stale or never-written storage.
  assign rd_entry      = mem_q[rd_ptr_q];
  assign bus.out_data  = out_valid_q ? rd_entry.data : '0;
  assign bus.out_class = out_valid_q ? rd_entry.cls  : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.level     = level_q;

endmodule

// File: doc/fp16_result_collector.md
FP16_RESULT_COLLECTOR -- requirements
Module: fp16_result_collector

Interface
REQ-001 SHALL have parameter bw, default 16: result word width; only fp16 layout (sign [16], exponent [15:11], mantissa [10:1]) is supported.
REQ-002 SHALL have parameter DEPTH, default 4: number of FIFO entries; power of two, minimum 2.
REQ-003 SHALL have port CLK  input  1  rising-edge clock for all state.
REQ-004 SHALL have port RESETn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  MAC result present on in_data.
REQ-006 SHALL have port in_data  input  [bw:1]  fp16 result from the MAC out port.
REQ-007 SHALL have port in_ready  output  1  collector can accept a word this cycle.
REQ-008 SHALL have port out_valid  output  1  out_data/out_class hold the oldest stored entry.
REQ-009 SHALL have port out_data  output  [bw:1]  oldest stored result.
REQ-010 SHALL have port out_class  output  [4:1]  class of out_data: [4] NaN, [3] Inf, [2] zero, [1] subnormal; 0000 = normal.
REQ-011 SHALL have port out_ready  input  1  downstream consumes the entry this cycle.
REQ-012 SHALL have port level  output  [log2(DEPTH)+1:1]  number of stored entries.

Function
REQ-013 Push SHALL occur on a rising CLK edge when in_valid and in_ready are both 1; pop SHALL occur when out_valid and out_ready are both 1.
REQ-014 in_ready SHALL equal (level < DEPTH), registered-state derived, no combinational path from out_ready.
REQ-015 out_valid SHALL equal (level != 0); out_data/out_class SHALL be valid the cycle after the push edge (1-cycle latency, empty to visible).
REQ-016 Class SHALL be computed at push time and stored with the word: NaN = exp 5'h1F and mantissa != 0; Inf = exp 5'h1F and mantissa == 0; zero = exp 0 and mantissa 0; subnormal = exp 0 and mantissa != 0; sign ignored; exactly one bit or none set.
REQ-017 Write and read pointers SHALL wrap modulo DEPTH; entries SHALL leave in push order.
REQ-018 Simultaneous push and pop SHALL leave level unchanged; when full, in_ready = 0 so no simultaneous push is accepted; when empty, no pop occurs.
REQ-019 in_valid while in_ready = 0 SHALL neither store nor corrupt data; the source must hold the word.
REQ-020 out_data/out_class SHALL remain stable while out_valid = 1 and out_ready = 0.
REQ-021 Status FSM SHALL track EMPTY (level 0), PARTIAL (0 < level < DEPTH), FULL (level DEPTH); transitions only via push/pop per REQ-013/018; EMPTY->FULL and FULL->EMPTY directly only when DEPTH is 1 (illegal, so never).

Reset
REQ-022 RESETn low SHALL asynchronously clear pointers, level = 0, FSM = EMPTY, out_valid = 0, in_ready = 1, out_data = 0, out_class = 0.
REQ-023 Reset asserted mid-stream SHALL discard all stored entries; first push after release SHALL be the first entry popped.

Configuration
REQ-024 Macro FP16_COLLECT_STATS_EN defined: SHALL add output nan_cnt [8:1], incremented on each pushed NaN, saturating at 8'hFF, cleared by reset.
REQ-025 Macro FP16_COLLECT_STATS_EN undefined: nan_cnt port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-026 Push 16'h4B9A with out_ready=0 -> next cycle out_valid=1, out_data=16'h4B9A, out_class=0000, level=1.
REQ-027 Push 7C01, 7C00, 8000, 0001 then drain with out_ready=1 -> classes 1000, 0100, 0010, 0001 in that order, level returns 0.
REQ-028 Push 5 words with out_ready=0, DEPTH=4 -> in_ready=0 after 4th, 5th not stored, pop order matches first 4.
REQ-029 At level=2, in_valid=1 and out_ready=1 for 6 cycles with incrementing data -> level stays 2, outputs in order, pointers wrap.
REQ-030 Drop RESETn at level=3 mid-cycle -> immediately level=0, out_valid=0, in_ready=1; next push 16'h3C00 pops first.
REQ-031 With FP16_COLLECT_STATS_EN, push 300 words of 16'h7E00 while draining -> nan_cnt=8'hFF.
